// File: rtl/otter_clk_pkg.sv
// rtl/otter_clk_pkg.sv - shared states and mode encodings for the OTTER clock/reset controller
package otter_clk_pkg;

    typedef enum logic [1:0] {
        S_RESET = 2'd0,
        S_RUN   = 2'd1,
        S_HALT  = 2'd2,
        S_STEP  = 2'd3
    } clk_state_t;

    localparam logic [1:0] MODE_RUN  = 2'b00;
    localparam logic [1:0] MODE_HALT = 2'b01;
    localparam logic [1:0] MODE_STEP = 2'b10;

endpackage

// File: rtl/clk_en_div.sv
// rtl/clk_en_div.sv - one tick-gated clock-enable divider channel
module clk_en_div #(
    parameter int DIV_W = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             SRST,
    input  logic             TICK,
    input  logic [DIV_W-1:0] DIV,
    output logic             CE
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             ce_q, ce_d;

    // The >= compare lets a lowered DIV fire on the next tick instead of wrapping the counter.
    always_comb begin
        cnt_d = cnt_q;
        ce_d  = 1'b0;
        if (SRST) begin
            cnt_d = '0;
        end else if (TICK) begin
            if (cnt_q >= DIV) begin
                cnt_d = '0;
                ce_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + DIV_W'(1);
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            cnt_q <= '0;
            ce_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ce_q  <= ce_d;
        end
    end

    assign CE = ce_q;

endmodule

// File: rtl/otter_clk_rst_ctrl.sv
// rtl/otter_clk_rst_ctrl.sv - MCU reset sequencer, run/halt/step FSM, cycle counter and CE dividers
module otter_clk_rst_ctrl
    import otter_clk_pkg::*;
#(
    parameter int N_CH         = 4,
    parameter int DIV_W        = 8,
    parameter int RESET_CYCLES = 16,
    parameter int CNT_W        = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  SRST,
    input  logic [1:0]            MODE,
    input  logic                  STEP,
    input  logic [N_CH*DIV_W-1:0] DIV,
    output logic                  MCU_RST,
    output logic [N_CH-1:0]       CE,
    output logic                  HALTED,
    output logic [CNT_W-1:0]      CYCLE_CNT
);

    localparam int RC_W = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;

    clk_state_t       state_q, state_d;
    logic [RC_W-1:0]  rst_cnt_q, rst_cnt_d;
    logic             mcu_rst_q, mcu_rst_d;
    logic             halted_q, halted_d;
    logic             step_q, step_d;
    logic [CNT_W-1:0] cyc_cnt_q, cyc_cnt_d;
    logic             tick;

    assign tick = (state_q == S_RUN) || (state_q == S_STEP);

    always_comb begin
        state_d   = state_q;
        rst_cnt_d = rst_cnt_q;
        mcu_rst_d = mcu_rst_q;
        step_d    = STEP;
        cyc_cnt_d = tick ? cyc_cnt_q + CNT_W'(1) : cyc_cnt_q;
        if (SRST) begin
            state_d   = S_RESET;
            rst_cnt_d = '0;
            mcu_rst_d = 1'b1;
            cyc_cnt_d = '0;
        end else begin
            unique case (state_q)
                S_RESET: begin
                    rst_cnt_d = rst_cnt_q + RC_W'(1);
                    if (rst_cnt_q == RC_W'(RESET_CYCLES - 1)) begin
                        mcu_rst_d = 1'b0;
                        state_d   = (MODE == MODE_RUN) ? S_RUN : S_HALT;
                    end
                end
                S_RUN: begin
                    if (MODE != MODE_RUN) state_d = S_HALT;
                end
                // Only the step-enable mode accepts STEP; halt and reserved modes ignore it.
                S_HALT: begin
                    if (MODE == MODE_RUN)
                        state_d = S_RUN;
                    else if (MODE == MODE_STEP && STEP && !step_q)
                        state_d = S_STEP;
                end
                S_STEP: begin
                    state_d = (MODE == MODE_RUN) ? S_RUN : S_HALT;
                end
                default: state_d = S_RESET;
            endcase
        end
        halted_d = (state_d == S_HALT);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= S_RESET;
            rst_cnt_q <= '0;
            mcu_rst_q <= 1'b1;
            halted_q  <= 1'b0;
            step_q    <= 1'b0;
            cyc_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rst_cnt_q <= rst_cnt_d;
            mcu_rst_q <= mcu_rst_d;
            halted_q  <= halted_d;
            step_q    <= step_d;
            cyc_cnt_q <= cyc_cnt_d;
        end
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_div
        clk_en_div #(.DIV_W(DIV_W)) u_div (
            .CLK  (CLK),
            .RST  (RST),
            .SRST (SRST),
            .TICK (tick),
            .DIV  (DIV[i*DIV_W +: DIV_W]),
            .CE   (CE[i])
        );
    end

    assign MCU_RST   = mcu_rst_q;
    assign HALTED    = halted_q;
    assign CYCLE_CNT = cyc_cnt_q;

endmodule

// File: tb/tb_otter_clk_rst_ctrl.sv
// tb/tb_otter_clk_rst_ctrl.sv - directed self-checking bench for otter_clk_rst_ctrl
module tb_otter_clk_rst_ctrl;

    logic        CLK = 1'b0;
    logic        RST, SRST, STEP;
    logic [1:0]  MODE;
    logic [31:0] DIV;
    logic        MCU_RST, HALTED, MCU_RST4, HALTED4;
    logic [3:0]  CE, CE4;
    logic [31:0] CYCLE_CNT;
    logic [3:0]  CYCLE_CNT4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 CLK = ~CLK;

    otter_clk_rst_ctrl #(.N_CH(4), .DIV_W(8), .RESET_CYCLES(16), .CNT_W(32)) u_dut (
        .CLK(CLK), .RST(RST), .SRST(SRST), .MODE(MODE), .STEP(STEP), .DIV(DIV),
        .MCU_RST(MCU_RST), .CE(CE), .HALTED(HALTED), .CYCLE_CNT(CYCLE_CNT)
    );

    otter_clk_rst_ctrl #(.N_CH(4), .DIV_W(8), .RESET_CYCLES(16), .CNT_W(4)) u_dut4 (
        .CLK(CLK), .RST(RST), .SRST(SRST), .MODE(MODE), .STEP(STEP), .DIV(DIV),
        .MCU_RST(MCU_RST4), .CE(CE4), .HALTED(HALTED4), .CYCLE_CNT(CYCLE_CNT4)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // CE pattern on tick t with DIV = {3,2,1,0} counted from reset.
    function automatic logic [3:0] exp_ce(input int t);
        logic [3:0] v;
        for (int i = 0; i < 4; i++) v[i] = ((t % (i + 1)) == 0);
        return v;
    endfunction

    task automatic count_reset(input string tag);
        int n = 0;
        while (MCU_RST === 1'b1 && n < 40) begin
            cyc(1);
            n++;
        end
        chk(tag, 64'(n), 64'd16);
    endtask

    initial begin
        RST = 1'b1; SRST = 1'b0; MODE = 2'b00; STEP = 1'b0;
        DIV = {8'd3, 8'd2, 8'd1, 8'd0};
        cyc(3);
        chk("rst_mcu", 64'(MCU_RST), 64'd1);
        chk("rst_ce", 64'(CE), 64'd0);
        chk("rst_halted", 64'(HALTED), 64'd0);
        chk("rst_cnt", 64'(CYCLE_CNT), 64'd0);

        RST = 1'b0;
        count_reset("mcu_rst_len");
        chk("run_cnt0", 64'(CYCLE_CNT), 64'd0);
        chk("run_ce0", 64'(CE), 64'd0);
        for (int k = 1; k <= 12; k++) begin
            cyc(1);
            chk("run_cnt", 64'(CYCLE_CNT), 64'(k));
            chk("run_ce", 64'(CE), 64'(exp_ce(k)));
        end

        cyc(88);
        chk("cnt100", 64'(CYCLE_CNT), 64'd100);
        MODE = 2'b01;
        cyc(1);
        chk("halt_halted", 64'(HALTED), 64'd1);
        chk("halt_cnt", 64'(CYCLE_CNT), 64'd101);
        chk("halt_last_ce", 64'(CE), 64'b0001);
        cyc(3);
        chk("halt_ce", 64'(CE), 64'd0);
        chk("halt_frozen", 64'(CYCLE_CNT), 64'd101);
        MODE = 2'b00;
        cyc(1);
        chk("resume_halted", 64'(HALTED), 64'd0);
        chk("resume_cnt", 64'(CYCLE_CNT), 64'd101);
        cyc(1);
        chk("resume_cnt102", 64'(CYCLE_CNT), 64'd102);
        chk("resume_ce102", 64'(CE), 64'(exp_ce(102)));
        cyc(1);
        chk("resume_ce103", 64'(CE), 64'(exp_ce(103)));

        MODE = 2'b10;
        cyc(1);
        chk("step_halt", 64'(HALTED), 64'd1);
        chk("step_cnt0", 64'(CYCLE_CNT), 64'd104);
        for (int s = 1; s <= 3; s++) begin
            STEP = 1'b1;
            cyc(1);
            chk("step_halted_low", 64'(HALTED), 64'd0);
            cyc(1);
            chk("step_halted_back", 64'(HALTED), 64'd1);
            chk("step_cnt", 64'(CYCLE_CNT), 64'(104 + s));
            cyc(2);
            chk("step_held", 64'(CYCLE_CNT), 64'(104 + s));
            STEP = 1'b0;
            cyc(4);
        end

        DIV[7:0] = 8'd10;
        MODE = 2'b00;
        cyc(8);
        chk("div10_no_ce", 64'(CE[0]), 64'd0);
        DIV[7:0] = 8'd3;
        for (int j = 0; j < 8; j++) begin
            cyc(1);
            chk("div_lowered", 64'(CE[0]), 64'((j % 4) == 0));
        end

        SRST = 1'b1;
        cyc(1);
        chk("srst_mcu", 64'(MCU_RST), 64'd1);
        chk("srst_cnt", 64'(CYCLE_CNT), 64'd0);
        chk("srst_ce", 64'(CE), 64'd0);
        cyc(1);
        chk("srst_hold", 64'(MCU_RST), 64'd1);
        SRST = 1'b0;
        count_reset("srst_len");
        for (int k = 1; k <= 20; k++) begin
            cyc(1);
            chk("wrap_cnt4", 64'(CYCLE_CNT4), 64'(k % 16));
        end
        chk("wrap_cnt4_final", 64'(CYCLE_CNT4), 64'd4);
        chk("wrap_cnt32", 64'(CYCLE_CNT), 64'd20);

        MODE = 2'b10;
        cyc(1);
        chk("pre_step_cnt", 64'(CYCLE_CNT), 64'd21);
        STEP = 1'b1;
        cyc(1);
        chk("in_step", 64'(HALTED), 64'd0);
        chk("in_step_mcu", 64'(MCU_RST), 64'd0);
        #2;
        RST = 1'b1;
        #1;
        chk("async_mcu", 64'(MCU_RST), 64'd1);
        chk("async_cnt", 64'(CYCLE_CNT), 64'd0);
        chk("async_ce", 64'(CE), 64'd0);
        chk("async_halted", 64'(HALTED), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
